// File: rtl/hdmi_pkg.sv
// Shared types, TMDS symbol constants and the 8b decode helper for the
// per-channel HDMI TMDS decoder. Symbol values are in HDMI notation q[9:0].
package hdmi_pkg;

    typedef enum logic [1:0] {
        SYM_CTL   = 2'd0,
        SYM_VIDEO = 2'd1,
        SYM_DATA  = 2'd2,
        SYM_GUARD = 2'd3
    } sym_type_e;

    typedef enum logic [3:0] {
        ST_CTL,
        ST_VGUARD1,
        ST_VGUARD2,
        ST_VIDEO,
        ST_DLEAD1,
        ST_DLEAD2,
        ST_DATA,
        ST_DTRAIL1,
        ST_DTRAIL2
    } period_state_e;

    // Control tokens, named by the {C1,C0} pair they carry.
    localparam logic [9:0] CTL_TOKEN_00 = 10'h354;
    localparam logic [9:0] CTL_TOKEN_01 = 10'h0AB;
    localparam logic [9:0] CTL_TOKEN_10 = 10'h154;
    localparam logic [9:0] CTL_TOKEN_11 = 10'h2AB;

    // Guard bands. Channel 0 has no distinct data guard band.
    localparam logic [9:0] VGB_CH02 = 10'h2CC;
    localparam logic [9:0] VGB_CH1  = 10'h133;
    localparam logic [9:0] DGB_CH12 = 10'h133;

    // TERC4 code words, index = nibble.
    localparam logic [15:0][9:0] TERC4_TABLE = {
        10'h2C3, 10'h163, 10'h271, 10'h28E, 10'h2C6, 10'h19C, 10'h139, 10'h2CC,
        10'h13C, 10'h18E, 10'h11E, 10'h171, 10'h2E2, 10'h2E4, 10'h263, 10'h29C
    };

    // Stage-1 classification result, registered as one word in the top.
    typedef struct packed {
        logic       is_ctl;
        logic [1:0] ctl;
        logic       is_vgb;
        logic       is_dgb;
        logic       is_terc4;
        logic [3:0] nibble;
        logic [7:0] data;
    } sym_flags_t;

    // TMDS transition-minimised 8b decode (q[9] = inverted, q[8] = XOR mode).
    function automatic logic [7:0] tmds_decode8(input logic [9:0] q);
        logic [7:0] dp;
        logic [7:0] d;
        dp   = q[9] ? ~q[7:0] : q[7:0];
        d    = '0;
        d[0] = dp[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (dp[i] ^ dp[i-1]) : ~(dp[i] ^ dp[i-1]);
        end
        return d;
    endfunction

endpackage

// File: rtl/hdmi_tmds_decode_classify.sv
// Combinational stage-1 classifier: bit-reverses the aligner symbol into
// HDMI notation, recognises control/guard/TERC4 code words and decodes the
// 8b video byte. The parent registers the result.
module tmds_symbol_classify
    import hdmi_pkg::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic [9:0] i_pix,
    output sym_flags_t o_flags
);

    localparam logic [9:0] VGB_SYM = (CHANNEL == 1) ? VGB_CH1 : VGB_CH02;

    logic [9:0] w_q;

    for (genvar i = 0; i < 10; i++) begin : g_rev
        assign w_q[i] = i_pix[9 - i];
    end

    // Classify the symbol and decode every payload form in parallel.
    always_comb begin
        o_flags      = '0;
        o_flags.data = tmds_decode8(w_q);
        case (w_q)
            CTL_TOKEN_00: begin o_flags.is_ctl = 1'b1; o_flags.ctl = 2'b00; end
            CTL_TOKEN_01: begin o_flags.is_ctl = 1'b1; o_flags.ctl = 2'b01; end
            CTL_TOKEN_10: begin o_flags.is_ctl = 1'b1; o_flags.ctl = 2'b10; end
            CTL_TOKEN_11: begin o_flags.is_ctl = 1'b1; o_flags.ctl = 2'b11; end
            default:      ;
        endcase
        o_flags.is_vgb = (w_q == VGB_SYM);
        o_flags.is_dgb = (CHANNEL != 0) && (w_q == DGB_CH12);
        for (int n = 0; n < 16; n++) begin
            if (w_q == TERC4_TABLE[n]) begin
                o_flags.is_terc4 = 1'b1;
                o_flags.nibble   = 4'(n);
            end
        end
    end

endmodule

// File: rtl/hdmi_tmds_decode.sv
// Per-channel TMDS decoder: stage 1 registers the classified symbol, stage 2
// tracks the HDMI period (control / video / data island) and registers the
// outputs. Latency from i_pix to outputs is two clocks.
// o_valid qualifies every other output on the same cycle; there is no
// backpressure, a symbol is produced every clock while sync is held.
module hdmi_tmds_decode
    import hdmi_pkg::*;
#(
    parameter int CHANNEL = 0,
    parameter int MIN_CTL = 8,
    parameter int ERRW    = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [4:0]      i_sync,
    input  logic [9:0]      i_pix,
    output logic            o_valid,
    output logic [1:0]      o_type,
    output logic [1:0]      o_ctl,
    output logic [7:0]      o_data,
    output logic [3:0]      o_terc4,
    output logic            o_err,
    output logic [ERRW-1:0] o_err_count
);

    sym_flags_t    w_flags;
    sym_flags_t    r_flags;
    logic          r_sync_ok;
    period_state_e r_state;
    period_state_e w_state_nxt;
    logic [3:0]    r_ctl_run;
    logic          w_run_ok;
    sym_type_e     w_type;
    logic          w_upd_ctl;
    logic          w_err;
    logic          w_unused_slip;

    // The bit-slip location is consumed by the aligner, not here.
    assign w_unused_slip = ^i_sync[3:0];

    tmds_symbol_classify #(.CHANNEL(CHANNEL)) u_classify (
        .i_pix   (i_pix),
        .o_flags (w_flags)
    );

    // Stage 1: register the classification and the sync qualifier.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_flags   <= '0;
            r_sync_ok <= 1'b0;
        end else begin
            r_flags   <= w_flags;
            r_sync_ok <= i_sync[4];
        end
    end

    // Preamble length is judged on the control symbols preceding this one.
    assign w_run_ok = (int'(r_ctl_run) >= MIN_CTL);

    // Period state machine: next state, emitted type and error flag.
    // Channel 1 cannot tell video and data guard bands apart, so both enter
    // the DLEAD path and the symbol after the two guards decides.
    always_comb begin
        w_state_nxt = r_state;
        w_type      = SYM_VIDEO;
        w_upd_ctl   = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_CTL: begin
                if (r_flags.is_ctl) begin
                    w_type    = SYM_CTL;
                    w_upd_ctl = 1'b1;
                end else if (CHANNEL != 1 && r_flags.is_vgb && w_run_ok) begin
                    w_state_nxt = ST_VGUARD1;
                    w_type      = SYM_GUARD;
                end else if (CHANNEL != 0 && r_flags.is_dgb && w_run_ok) begin
                    w_state_nxt = ST_DLEAD1;
                    w_type      = SYM_GUARD;
                end else if (CHANNEL == 0 && r_flags.is_terc4 && w_run_ok) begin
                    w_state_nxt = ST_DATA;
                    w_type      = SYM_DATA;
                end else begin
                    w_err = 1'b1;
                end
            end
            ST_VGUARD1: begin
                if (r_flags.is_vgb) begin
                    w_state_nxt = ST_VGUARD2;
                    w_type      = SYM_GUARD;
                end else begin
                    w_state_nxt = ST_CTL;
                    w_err       = 1'b1;
                end
            end
            ST_VGUARD2: begin
                w_state_nxt = ST_VIDEO;
            end
            ST_VIDEO: begin
                if (r_flags.is_ctl) begin
                    w_state_nxt = ST_CTL;
                    w_type      = SYM_CTL;
                    w_upd_ctl   = 1'b1;
                end
            end
            ST_DLEAD1: begin
                if (r_flags.is_dgb) begin
                    w_state_nxt = ST_DLEAD2;
                    w_type      = SYM_GUARD;
                end else begin
                    w_state_nxt = ST_CTL;
                    w_err       = 1'b1;
                end
            end
            ST_DLEAD2: begin
                if (r_flags.is_terc4) begin
                    w_state_nxt = ST_DATA;
                    w_type      = SYM_DATA;
                end else if (CHANNEL == 1) begin
                    w_state_nxt = ST_VIDEO;
                end else begin
                    w_state_nxt = ST_CTL;
                    w_err       = 1'b1;
                end
            end
            ST_DATA: begin
                if (CHANNEL != 0 && r_flags.is_dgb) begin
                    w_state_nxt = ST_DTRAIL1;
                    w_type      = SYM_GUARD;
                end else if (r_flags.is_terc4) begin
                    w_type = SYM_DATA;
                end else if (r_flags.is_ctl) begin
                    w_state_nxt = ST_CTL;
                    w_type      = SYM_CTL;
                    w_upd_ctl   = 1'b1;
                end else begin
                    w_err = 1'b1;
                end
            end
            ST_DTRAIL1: begin
                if (r_flags.is_dgb) begin
                    w_state_nxt = ST_DTRAIL2;
                    w_type      = SYM_GUARD;
                end else begin
                    w_state_nxt = ST_CTL;
                    w_err       = 1'b1;
                end
            end
            ST_DTRAIL2: begin
                w_state_nxt = ST_CTL;
                if (r_flags.is_ctl) begin
                    w_type    = SYM_CTL;
                    w_upd_ctl = 1'b1;
                end else begin
                    w_err = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_CTL;
            end
        endcase
    end

    // Stage 2: state, preamble run counter and output registers.
    // Losing sync drops back to CTL silently; payload outputs hold.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_CTL;
            r_ctl_run   <= 4'd0;
            o_valid     <= 1'b0;
            o_type      <= SYM_CTL;
            o_ctl       <= 2'b00;
            o_data      <= 8'd0;
            o_terc4     <= 4'd0;
            o_err       <= 1'b0;
            o_err_count <= '0;
        end else if (!r_sync_ok) begin
            r_state   <= ST_CTL;
            r_ctl_run <= 4'd0;
            o_valid   <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (!r_flags.is_ctl) begin
                r_ctl_run <= 4'd0;
            end else if (r_ctl_run != 4'd15) begin
                r_ctl_run <= r_ctl_run + 4'd1;
            end
            o_valid <= 1'b1;
            o_type  <= w_type;
            if (w_upd_ctl) begin
                o_ctl <= r_flags.ctl;
            end
            o_data  <= r_flags.data;
            o_terc4 <= r_flags.nibble;
            o_err   <= w_err;
            if (w_err && !(&o_err_count)) begin
                o_err_count <= o_err_count + ERRW'(1);
            end
        end
    end

endmodule
